// File: rtl/window_monitor_pkg.sv
// Shared types for the window monitor: zone and FSM state encodings, the debounce
// counter width, and the conversion helpers between zone and state.
package window_monitor_pkg;

  typedef enum logic [1:0] {
    ZONE_BELOW  = 2'd0,
    ZONE_INSIDE = 2'd1,
    ZONE_ABOVE  = 2'd2
  } zone_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_BELOW,
    ST_INSIDE,
    ST_ABOVE
  } state_t;

  localparam int CNT_W = 8;

  // INIT has not committed to a zone yet, so it reads as INSIDE.
  function automatic zone_t state_zone(input state_t s);
    case (s)
      ST_BELOW: return ZONE_BELOW;
      ST_ABOVE: return ZONE_ABOVE;
      default:  return ZONE_INSIDE;
    endcase
  endfunction

  function automatic state_t zone_state(input zone_t z);
    case (z)
      ZONE_BELOW: return ST_BELOW;
      ZONE_ABOVE: return ST_ABOVE;
      default:    return ST_INSIDE;
    endcase
  endfunction

endpackage

// File: rtl/window_classify.sv
// Combinational three-way window compare. The bounds themselves count as INSIDE;
// samples and bounds share one fixed-point format, so the codes are compared directly.
module window_classify
  import window_monitor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] sample,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  output zone_t                   zone
);

  always_comb begin
    zone = ZONE_INSIDE;
    if (sample > hi) begin
      zone = ZONE_ABOVE;
    end else if (sample < lo) begin
      zone = ZONE_BELOW;
    end
  end

endmodule

// File: rtl/window_monitor.sv
// Window monitor: registered per-sample classification plus a debounced zone FSM.
// Optional macro WINDOW_MONITOR_STATS_EN adds a saturating zone-change counter output.
module window_monitor
  import window_monitor_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int EXP      = -8,
  parameter int DEBOUNCE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] thr_lo,
  input  logic signed [WIDTH-1:0] thr_hi,
  output logic [1:0]              raw_zone,
  output logic                    out_valid,
  output logic [1:0]              zone,
  output logic                    zone_chg,
  output logic                    cfg_err
`ifdef WINDOW_MONITOR_STATS_EN
  ,
  output logic [15:0]             chg_count
`endif
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  zone_t             cls_zone_p0;
  state_t            state, state_next;
  zone_t             cand, cand_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              chg_next;

  zone_t             raw_zone_p1;
  logic              vld_p1;
  logic              zone_chg_p1;

  assign cfg_err = (thr_lo > thr_hi);

  window_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .sample (in_data),
    .lo     (thr_lo),
    .hi     (thr_hi),
    .zone   (cls_zone_p0)
  );

  // Debounce decision. The counter holds the trailing run length of the current
  // candidate; zero means no candidate is pending.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    chg_next   = 1'b0;
    if (in_valid && cfg_err) begin
      cnt_next = '0;
    end else if (in_valid) begin
      if (state == ST_INIT) begin
        state_next = zone_state(cls_zone_p0);
        cnt_next   = '0;
        chg_next   = 1'b1;
      end else if (cls_zone_p0 == state_zone(state)) begin
        cnt_next = '0;
      end else begin
        if (cnt == '0 || cls_zone_p0 != cand) begin
          cand_next = cls_zone_p0;
          cnt_next  = CNT_W'(1);
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
        if (cnt_next == DEB) begin
          state_next = zone_state(cls_zone_p0);
          cnt_next   = '0;
          chg_next   = 1'b1;
        end
      end
    end
  end

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      cand        <= ZONE_INSIDE;
      cnt         <= '0;
      vld_p1      <= 1'b0;
      raw_zone_p1 <= ZONE_INSIDE;
      zone_chg_p1 <= 1'b0;
    end else begin
      state       <= state_next;
      cand        <= cand_next;
      cnt         <= cnt_next;
      vld_p1      <= in_valid;
      zone_chg_p1 <= chg_next;
      if (in_valid) begin
        raw_zone_p1 <= cls_zone_p0;
      end
    end
  end

  assign raw_zone  = raw_zone_p1;
  assign out_valid = vld_p1;
  assign zone      = state_zone(state);
  assign zone_chg  = zone_chg_p1;

`ifdef WINDOW_MONITOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_count <= '0;
    end else if (zone_chg_p1 && chg_count != 16'hFFFF) begin
      chg_count <= chg_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_monitor.sv
// Self-checking bench for window_monitor (default build, WIDTH 16, DEBOUNCE 4):
// directed scenarios plus randomized zone runs compared against a queue-based model.
module tb_window_monitor;

  localparam int WIDTH = 16;
  localparam int DEB   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [WIDTH-1:0] in_data = '0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] thr_lo = '0;
  logic signed [WIDTH-1:0] thr_hi = '0;
  logic [1:0]              raw_zone;
  logic                    out_valid;
  logic [1:0]              zone;
  logic                    zone_chg;
  logic                    cfg_err;

  window_monitor #(.WIDTH(WIDTH), .EXP(-8), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .thr_lo    (thr_lo),
    .thr_hi    (thr_hi),
    .raw_zone  (raw_zone),
    .out_valid (out_valid),
    .zone      (zone),
    .zone_chg  (zone_chg),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: zones 0 BELOW, 1 INSIDE, 2 ABOVE.
  int cur_lo = -256;
  int cur_hi = 512;
  bit m_init = 1'b1;
  int m_zone = 1;
  int m_raw  = 1;
  bit m_ov   = 1'b0;
  bit m_chg  = 1'b0;
  int hist[$];

  function automatic int classify(input int d, input int lo, input int hi);
    if (d > hi) return 2;
    if (d < lo) return 0;
    return 1;
  endfunction

  // A zone change happens once the last DEB accepted samples since the previous
  // change all agree on one zone other than the current one.
  task automatic model_sample(input bit v, input int d);
    int  r;
    bit  run;
    m_chg = 1'b0;
    m_ov  = v;
    if (v) begin
      r     = classify(d, cur_lo, cur_hi);
      m_raw = r;
      if (cur_lo > cur_hi) begin
        hist.delete();
      end else if (m_init) begin
        m_init = 1'b0;
        m_zone = r;
        m_chg  = 1'b1;
        hist.delete();
      end else begin
        hist.push_back(r);
        if (hist.size() > DEB) void'(hist.pop_front());
        run = (hist.size() == DEB) && (r != m_zone);
        foreach (hist[k]) if (hist[k] != r) run = 1'b0;
        if (run) begin
          m_zone = r;
          m_chg  = 1'b1;
          hist.delete();
        end
      end
    end
  endtask

  task automatic drive(input bit v, input int d);
    in_valid = v;
    in_data  = WIDTH'(d);
    thr_lo   = WIDTH'(cur_lo);
    thr_hi   = WIDTH'(cur_hi);
    @(posedge clk);
    model_sample(v, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = WIDTH'(700);
    @(posedge clk);
    m_init = 1'b1; m_zone = 1; m_raw = 1; m_ov = 1'b0; m_chg = 1'b0;
    hist.delete();
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got=%0b want=0", out_valid); end
    if (raw_zone !== 2'd1) begin n_fail++; $display("FAIL reset raw_zone got=%0d want=1", raw_zone); end
    if (zone !== 2'd1) begin n_fail++; $display("FAIL reset zone got=%0d want=1", zone); end
    if (zone_chg !== 1'b0) begin n_fail++; $display("FAIL reset zone_chg got=%0b want=0", zone_chg); end
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset cfg_err got=%0b want=0", cfg_err); end
  endtask

  task automatic test_first_sample();
    drive(1'b1, 0);
    n_chk += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first out_valid got=%0b want=1", out_valid); end
    if (raw_zone !== 2'd1) begin n_fail++; $display("FAIL first raw_zone got=%0d want=1", raw_zone); end
    if (zone !== 2'd1) begin n_fail++; $display("FAIL first zone got=%0d want=1", zone); end
    if (zone_chg !== 1'b1) begin n_fail++; $display("FAIL first zone_chg got=%0b want=1", zone_chg); end
    drive(1'b0, 0);
    n_chk += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first idle out_valid got=%0b want=0", out_valid); end
    if (zone_chg !== 1'b0) begin n_fail++; $display("FAIL first idle zone_chg got=%0b want=0", zone_chg); end
  endtask

  // Drive a stimulus list and compare every result cycle against the model.
  task automatic test_seq(input string name, input int vals[$], input bit vld[$]);
    foreach (vals[i]) begin
      drive(vld[i], vals[i]);
      n_chk += 5;
      if (out_valid !== m_ov) begin n_fail++; $display("FAIL %s[%0d] out_valid got=%0b want=%0b", name, i, out_valid, m_ov); end
      if (raw_zone !== 2'(m_raw)) begin n_fail++; $display("FAIL %s[%0d] raw_zone got=%0d want=%0d", name, i, raw_zone, m_raw); end
      if (zone !== 2'(m_zone)) begin n_fail++; $display("FAIL %s[%0d] zone got=%0d want=%0d", name, i, zone, m_zone); end
      if (zone_chg !== m_chg) begin n_fail++; $display("FAIL %s[%0d] zone_chg got=%0b want=%0b", name, i, zone_chg, m_chg); end
      if (cfg_err !== (cur_lo > cur_hi)) begin n_fail++; $display("FAIL %s[%0d] cfg_err got=%0b want=%0b", name, i, cfg_err, cur_lo > cur_hi); end
    end
  endtask

  task automatic test_above_debounce();
    test_seq("above", '{512, 512, 512, 512, 512, 513, 513, 513, 513},
                      '{1, 1, 1, 1, 1, 1, 1, 1, 1});
    n_chk += 2;
    if (zone !== 2'd2) begin n_fail++; $display("FAIL above final zone got=%0d want=2", zone); end
    if (zone_chg !== 1'b1) begin n_fail++; $display("FAIL above final zone_chg got=%0b want=1", zone_chg); end
  endtask

  task automatic test_counter_restart();
    do_reset();
    drive(1'b1, 0);
    test_seq("restart", '{600, 600, 0, 600, 600, 600}, '{1, 1, 1, 1, 1, 1});
    n_chk++;
    if (zone !== 2'd1) begin n_fail++; $display("FAIL restart early zone got=%0d want=1", zone); end
    test_seq("restart_last", '{600}, '{1});
    n_chk++;
    if (zone !== 2'd2 || zone_chg !== 1'b1) begin
      n_fail++; $display("FAIL restart final zone/chg got=%0d/%0b want=2/1", zone, zone_chg);
    end
  endtask

  task automatic test_gaps();
    test_seq("gaps", '{-300, 0, -300, 0, 0, -300, 0, -300, 0},
                     '{1, 0, 1, 0, 0, 1, 0, 1, 0});
    n_chk++;
    if (zone !== 2'd0) begin n_fail++; $display("FAIL gaps final zone got=%0d want=0", zone); end
  endtask

  task automatic test_cfg_err();
    int ten[$];
    bit ones[$];
    int z0;
    z0 = zone;
    cur_lo = 600; cur_hi = 100;
    for (int i = 0; i < 10; i++) begin ten.push_back(1000); ones.push_back(1'b1); end
    test_seq("cfg", ten, ones);
    n_chk += 2;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg cfg_err got=%0b want=1", cfg_err); end
    if (zone !== 2'(z0)) begin n_fail++; $display("FAIL cfg frozen zone got=%0d want=%0d", zone, z0); end
    cur_lo = -256; cur_hi = 512;
    test_seq("cfg_restore", '{1000, 1000, 1000, 1000}, '{1, 1, 1, 1});
    n_chk++;
    if (zone !== 2'd2) begin n_fail++; $display("FAIL cfg restore zone got=%0d want=2", zone); end
  endtask

  task automatic test_equal_thr();
    cur_lo = 100; cur_hi = 100;
    test_seq("eqthr", '{100, 101, 99, 100}, '{1, 1, 1, 1});
    cur_lo = -256; cur_hi = 512;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 0);
    test_seq("midrst", '{513, 513, 513}, '{1, 1, 1});
    do_reset();
    n_chk += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got=%0b want=0", out_valid); end
    if (raw_zone !== 2'd1) begin n_fail++; $display("FAIL midrst raw_zone got=%0d want=1", raw_zone); end
    if (zone !== 2'd1) begin n_fail++; $display("FAIL midrst zone got=%0d want=1", zone); end
    if (zone_chg !== 1'b0) begin n_fail++; $display("FAIL midrst zone_chg got=%0b want=0", zone_chg); end
    test_seq("midrst_init", '{-300}, '{1});
    n_chk++;
    if (zone !== 2'd0 || zone_chg !== 1'b1) begin
      n_fail++; $display("FAIL midrst init zone/chg got=%0d/%0b want=0/1", zone, zone_chg);
    end
  endtask

  task automatic test_random();
    int vals[$];
    bit vld[$];
    int tgt;
    tgt = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 250) begin
        test_seq("rand", vals, vld);
        vals.delete(); vld.delete();
        cur_lo = 300; cur_hi = -100;
      end
      if (i == 300) begin
        test_seq("rand_cfg", vals, vld);
        vals.delete(); vld.delete();
        cur_lo = -256; cur_hi = 512;
      end
      if ($urandom_range(0, 9) < 2) tgt = int'($urandom_range(0, 2));
      case (tgt)
        0:       vals.push_back(-int'($urandom_range(257, 900)));
        2:       vals.push_back(int'($urandom_range(513, 1200)));
        default: vals.push_back(int'($urandom_range(0, 768)) - 256);
      endcase
      vld.push_back($urandom_range(0, 9) < 7);
    end
    test_seq("rand_end", vals, vld);
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_above_debounce();
    test_counter_restart();
    test_gaps();
    test_cfg_err();
    test_equal_thr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/window_monitor.md
WINDOW_MONITOR -- requirements
Module: window_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning fixed-point sample and threshold width in bits (signed).
REQ-002 The block SHALL have parameter EXP, default -8, meaning binary exponent; represented value = code * 2^EXP, identical for samples and thresholds.
REQ-003 The block SHALL have parameter DEBOUNCE, default 4, range 1..255, meaning consecutive qualifying samples required to change zone.
REQ-004 The block SHALL have port clk  input  1  sole clock.
REQ-005 The block SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 The block SHALL have port in_data  input  WIDTH  signed sample code.
REQ-007 The block SHALL have port in_valid  input  1  sample qualifier.
REQ-008 The block SHALL have port thr_lo, thr_hi  input  WIDTH each  signed window bounds, quasi-static.
REQ-009 The block SHALL have port raw_zone  output  2  registered per-sample classification.
REQ-010 The block SHALL have port out_valid  output  1  raw_zone qualifier.
REQ-011 The block SHALL have port zone  output  2  debounced zone (0 BELOW, 1 INSIDE, 2 ABOVE).
REQ-012 The block SHALL have port zone_chg  output  1  one-cycle pulse when zone changes.
REQ-013 The block SHALL have port cfg_err  output  1  high while thr_lo > thr_hi.

Function
REQ-014 Classification SHALL be ABOVE if in_data > thr_hi, BELOW if in_data < thr_lo, otherwise INSIDE; bounds inclusive to INSIDE; signed compare, no rescaling.
REQ-015 Latency SHALL be one cycle: in_valid at edge N gives out_valid=1 and raw_zone at N+1; out_valid=0 otherwise.
REQ-016 FSM states SHALL be INIT, BELOW, INSIDE, ABOVE; zone output in INIT reads INSIDE.
REQ-017 INIT SHALL go to the raw zone of the first accepted sample without debounce, asserting zone_chg.
REQ-018 In a settled state, a sample whose raw zone differs SHALL become candidate; counter increments per consecutive accepted sample with the same candidate.
REQ-019 Counter SHALL reset to 0 when a sample matches the current state, and to 1 when the candidate changes.
REQ-020 On count reaching DEBOUNCE, state SHALL move to candidate, counter clears, zone_chg pulses with zone updated the same cycle (BELOW->ABOVE direct allowed).
REQ-021 Cycles with in_valid=0 SHALL leave counter and state unchanged.
REQ-022 While cfg_err=1, samples SHALL produce out_valid/raw_zone but SHALL NOT advance counter or state; counter clears.
REQ-023 thr_lo == thr_hi SHALL be legal (cfg_err=0).

Reset
REQ-024 rst_n low at a clock edge SHALL set state INIT, counter 0, out_valid 0, raw_zone INSIDE, zone INSIDE, zone_chg 0; cfg_err combinational; mid-debounce progress is discarded.

Configuration
REQ-025 With WINDOW_MONITOR_STATS_EN defined, the block SHALL add output chg_count (16 bits) counting zone_chg pulses, saturating at 65535, cleared by reset; without it the port and logic SHALL be absent.

Structure
REQ-026 Package window_monitor_pkg SHALL hold zone_t enum (BELOW, INSIDE, ABOVE), state enum, and the debounce counter width constant (8).
REQ-027 Sub-module window_classify SHALL hold the combinational three-way compare; the FSM and registers SHALL stay in window_monitor.

Verification (WIDTH 16, EXP -8, thr_lo=-256 (-1.0), thr_hi=512 (2.0), DEBOUNCE 4)
REQ-028 Reset, then first sample 0 -> next cycle raw_zone INSIDE, zone INSIDE, zone_chg=1.
REQ-029 Four consecutive samples 513 -> zone ABOVE and zone_chg on 4th result cycle; samples of exactly 512 stay INSIDE.
REQ-030 Samples 600,600,0,600,600,600,600 -> change only after the final 600 (counter reset by 0).
REQ-031 Samples -300 x3 with in_valid gaps between, then one more -300 -> zone BELOW after the 4th valid sample.
REQ-032 thr_lo=600, thr_hi=100 -> cfg_err=1, zone frozen over 10 samples of 1000; restore thresholds -> debounce restarts from 0.
REQ-033 rst_n low after 3 of 4 qualifying samples -> all outputs at reset values; next sample treated as INIT.
